// File: rtl/cp0_int_ctrl_if.sv
// cp0_int_ctrl_if: register-window bus between a CPU-side master and the interrupt controller
//   addr  byte address, we write enable, wdata write data, rdata combinational read data
interface cp0_int_ctrl_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output addr, we, wdata, input rdata);
  modport slave (input addr, we, wdata, output rdata);
endinterface

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: interrupt controller feeding CP0 hwint with a one-hot, fixed-priority request
//   clk     clock
//   clr     synchronous active-high reset
//   irq_in  raw device IRQ lines
//   intreq  CP0 taking an interrupt/exception this cycle
//   exlclr  eret retiring
//   bus     register window: PEND (W1C), MASK, MODE (1=edge), CUR ([31] valid, [2:0] id)
//   hwint   registered one-hot request to CP0
//   IRQ_SYNC_EN: when defined, irq_in passes a 2-flop synchronizer first
module cp0_int_ctrl #(
  parameter int          NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = 32'h7F20
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NSRC-1:0]   irq_in,
  input  logic              intreq,
  input  logic              exlclr,
  cp0_int_ctrl_if.slave     bus,
  output logic [NSRC-1:0]   hwint
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
  state_t state;
  logic [NSRC-1:0] irq_s, irq_q, pend, mask, mode, req, rise, w1c, svc;
  logic [2:0] sel, win, cur_id;
  logic [1:0] idx;
  logic cur_v, hit, wr, take, unused;
`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] s1, s2;
  always_ff @(posedge clk) begin
    s1 <= clr ? '0 : irq_in;
    s2 <= clr ? '0 : s1;
  end
  assign irq_s = s2;
`else
  assign irq_s = irq_in;
`endif
  assign unused = ^{bus.addr[1:0], bus.wdata[31:NSRC]};
  always_comb begin
    idx = bus.addr[3:2];
    hit = bus.addr[31:4] == BASE_ADDR[31:4];
    wr = hit && bus.we;
    rise = irq_s & ~irq_q;
    req = pend & mask;
    win = req[0] ? 3'd0 : req[1] ? 3'd1 : req[2] ? 3'd2 : req[3] ? 3'd3 : req[4] ? 3'd4 : 3'd5;
    take = state == ASSERT && req[sel] && intreq;
    w1c = (wr && idx == 2'd0) ? bus.wdata[NSRC-1:0] : '0;
    svc = take ? NSRC'(1) << sel : '0;
    bus.rdata = !hit ? 32'd0 :
                idx == 2'd0 ? 32'(pend) :
                idx == 2'd1 ? 32'(mask) :
                idx == 2'd2 ? 32'(mode) : {cur_v, 28'd0, cur_id};
  end
  // Edge bits: a new edge beats both W1C and the service-entry clear; level bits mirror the line.
  always_ff @(posedge clk) begin
    if (clr) begin
      irq_q <= '0;
      pend <= '0;
      mask <= '0;
      mode <= '0;
    end else begin
      irq_q <= irq_s;
      pend <= (mode & (rise | (pend & ~w1c & ~svc))) | (~mode & irq_s);
      if (wr && idx == 2'd1) mask <= bus.wdata[NSRC-1:0];
      if (wr && idx == 2'd2) mode <= bus.wdata[NSRC-1:0];
    end
  end
  // sel is frozen while asserting; a higher-priority arrival waits for the next IDLE pass.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      sel <= '0;
      hwint <= '0;
      cur_v <= 1'b0;
      cur_id <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= ASSERT;
          sel <= win;
          hwint <= NSRC'(1) << win;
        end
        ASSERT: if (!req[sel]) begin
          state <= IDLE;
          hwint <= '0;
        end else if (intreq) begin
          state <= SERVICE;
          hwint <= '0;
          cur_v <= 1'b1;
          cur_id <= sel;
        end
        SERVICE: if (exlclr) begin
          state <= IDLE;
          cur_v <= 1'b0;
          cur_id <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
